time_setter: RTL and testbench

TIME_SETTER -- requirements
Module: time_setter

---
 rtl/time_setter_pkg.sv | 28 ++
 rtl/btn_debounce.sv | 53 +++++
 rtl/time_setter.sv | 137 +++++++++++++
 tb/tb_time_setter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/time_setter_pkg.sv
// Shared types and constants for the time_setter block: FSM states, edit_field codes
// and the min/sec wrap-step helper.
package time_setter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EDIT_MIN = 2'd1,
    ST_EDIT_SEC = 2'd2,
    ST_OFFER    = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_SEC  = 2'd2;

  localparam logic [7:0] MAX_SEC = 8'd59;

  // One step up or down inside 0..max_val, wrapping at both ends
  function automatic logic [7:0] step_wrap(input logic [7:0] val, input logic [7:0] max_val,
                                           input logic up);
    if (up) begin
      return (val >= max_val) ? 8'd0 : val + 8'd1;
    end else begin
      return (val == 8'd0) ? max_val : val - 8'd1;
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, DEB_CYC-cycle debouncer and a
// one-cycle pulse on each debounced press (release gives no pulse).
module btn_debounce
  import time_setter_pkg::*;
#(
  parameter int DEB_CYC = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;

  // Synchronize, then accept a new level only after DEB_CYC consecutive differing samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      press_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r != level_r) begin
        if (cnt_r == CNT_LAST) begin
          level_r <= sync2_r;
          press_r <= sync2_r;
          cnt_r   <= {CW{1'b0}};
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  assign level = level_r;
  assign press = press_r;

endmodule

// File: rtl/time_setter.sv
// Button-driven min/sec editor that offers the value to a countdown timer via valid/ready.
// Optional hold-to-repeat on up/down is enabled with TIME_SETTER_AUTO_REPEAT_EN.
module time_setter
  import time_setter_pkg::*;
#(
  parameter int CLK_HZ      = 100000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int INIT_MIN    = 3,
  parameter int INIT_SEC    = 0,
  parameter int MAX_MIN     = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  input  logic       set_ready,
  output logic       set_valid,
  output logic [7:0] set_min,
  output logic [7:0] set_sec,
  output logic [1:0] edit_field
);

  localparam int DEB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam logic [7:0] MAX_MIN_V = 8'(MAX_MIN);

  state_t     state_r;
  logic [3:0] btn_s;
  logic [3:0] lvl_s;
  logic [3:0] press_s;
  logic       up_step_s;
  logic       down_step_s;
  logic       lvl_unused_s;

  assign btn_s = {btn_confirm, btn_down, btn_up, btn_mode};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_btn_debounce (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_s[i]),
      .level(lvl_s[i]),
      .press(press_s[i])
    );
  end

  // Held levels only matter for the repeat timer
  assign lvl_unused_s = ^lvl_s;

`ifdef TIME_SETTER_AUTO_REPEAT_EN
  localparam int HOLD_CYC = CLK_HZ / 1000 * 500;
  localparam int RPT_CYC  = CLK_HZ / 1000 * 100;

  logic [31:0] rpt_cnt_r;
  logic        rpt_pulse_r;

  // Time a single held up or down key: first repeat after HOLD_CYC, then every RPT_CYC
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_cnt_r   <= 32'd0;
      rpt_pulse_r <= 1'b0;
    end else begin
      rpt_pulse_r <= 1'b0;
      if ((state_r == ST_EDIT_MIN || state_r == ST_EDIT_SEC) && (lvl_s[1] ^ lvl_s[2])) begin
        if (rpt_cnt_r == 32'(HOLD_CYC - 1)) begin
          rpt_pulse_r <= 1'b1;
          rpt_cnt_r   <= 32'(HOLD_CYC - RPT_CYC);
        end else begin
          rpt_cnt_r <= rpt_cnt_r + 32'd1;
        end
      end else begin
        rpt_cnt_r <= 32'd0;
      end
    end
  end

  assign up_step_s   = press_s[1] | (rpt_pulse_r & lvl_s[1]);
  assign down_step_s = press_s[2] | (rpt_pulse_r & lvl_s[2]);
`else
  assign up_step_s   = press_s[1];
  assign down_step_s = press_s[2];
`endif

  // Edit FSM; confirm beats mode, mode beats up/down, up+down together cancel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      set_valid  <= 1'b0;
      edit_field <= FIELD_NONE;
      set_min    <= 8'(INIT_MIN);
      set_sec    <= 8'(INIT_SEC);
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (press_s[0]) begin
            state_r    <= ST_EDIT_MIN;
            edit_field <= FIELD_MIN;
          end
        end
        ST_EDIT_MIN, ST_EDIT_SEC: begin
          if (press_s[3]) begin
            state_r    <= ST_OFFER;
            edit_field <= FIELD_NONE;
            set_valid  <= 1'b1;
          end else if (press_s[0]) begin
            if (state_r == ST_EDIT_MIN) begin
              state_r    <= ST_EDIT_SEC;
              edit_field <= FIELD_SEC;
            end else begin
              state_r    <= ST_EDIT_MIN;
              edit_field <= FIELD_MIN;
            end
          end else if (up_step_s ^ down_step_s) begin
            if (state_r == ST_EDIT_MIN) begin
              set_min <= step_wrap(set_min, MAX_MIN_V, up_step_s);
            end else begin
              set_sec <= step_wrap(set_sec, MAX_SEC, up_step_s);
            end
          end
        end
        ST_OFFER: begin
          if (set_ready) begin
            state_r   <= ST_IDLE;
            set_valid <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          set_valid  <= 1'b0;
          edit_field <= FIELD_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_time_setter.sv
// Scoreboard bench for time_setter: stimulus pushes expected output tuples, a negedge
// monitor pops and compares on every change of {set_valid, set_min, set_sec, edit_field}.
module tb_time_setter;

  typedef struct packed {
    logic       valid;
    logic [7:0] min;
    logic [7:0] sec;
    logic [1:0] field;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode, btn_up, btn_down, btn_confirm;
  logic       set_ready;
  logic       set_valid;
  logic [7:0] set_min, set_sec;
  logic [1:0] edit_field;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  obs_t exp_q[$];
  obs_t prev_obs;

  time_setter #(
    .CLK_HZ     (1000),
    .DEBOUNCE_MS(3),
    .INIT_MIN   (3),
    .INIT_SEC   (0),
    .MAX_MIN    (99)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_confirm(btn_confirm),
    .set_ready  (set_ready),
    .set_valid  (set_valid),
    .set_min    (set_min),
    .set_sec    (set_sec),
    .edit_field (edit_field)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic v, input int mi, input int se, input int f);
    obs_t o;
    o.valid = v;
    o.min   = 8'(mi);
    o.sec   = 8'(se);
    o.field = 2'(f);
    return o;
  endfunction

  function automatic obs_t cur_obs();
    return {set_valid, set_min, set_sec, edit_field};
  endfunction

  // Monitor: every output change must match the next queued expectation
  always @(negedge clk) begin
    obs_t cur;
    obs_t e;
    cur = cur_obs();
    if (!mon_en) begin
      prev_obs = cur;
    end else if (cur !== prev_obs) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: got v=%0d min=%0d sec=%0d f=%0d, required no change from v=%0d min=%0d sec=%0d f=%0d",
                 cur.valid, cur.min, cur.sec, cur.field,
                 prev_obs.valid, prev_obs.min, prev_obs.sec, prev_obs.field);
      end else begin
        e = exp_q.pop_front();
        if (cur !== e) begin
          errors++;
          $display("FAIL scoreboard: got v=%0d min=%0d sec=%0d f=%0d, required v=%0d min=%0d sec=%0d f=%0d",
                   cur.valid, cur.min, cur.sec, cur.field, e.valid, e.min, e.sec, e.field);
        end
      end
      prev_obs = cur;
    end
  end

  task automatic check_now(input obs_t e, input string name);
    obs_t cur;
    cur = cur_obs();
    checks++;
    if (cur !== e) begin
      errors++;
      $display("FAIL %s: got v=%0d min=%0d sec=%0d f=%0d, required v=%0d min=%0d sec=%0d f=%0d",
               name, cur.valid, cur.min, cur.sec, cur.field, e.valid, e.min, e.sec, e.field);
    end
  endtask

  // btns order: {confirm, down, up, mode}
  task automatic press(input logic [3:0] btns, input int hold);
    @(negedge clk);
    {btn_confirm, btn_down, btn_up, btn_mode} = btns;
    repeat (hold) @(negedge clk);
    {btn_confirm, btn_down, btn_up, btn_mode} = 4'b0000;
    repeat (8) @(negedge clk);
  endtask

  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_UP   = 4'b0010;
  localparam logic [3:0] B_DOWN = 4'b0100;
  localparam logic [3:0] B_CONF = 4'b1000;

  initial begin
    int waited;
    rst_n = 1'b0;
    set_ready = 1'b0;
    {btn_confirm, btn_down, btn_up, btn_mode} = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_now(mk(1'b0, 3, 0, 0), "reset_state");
    mon_en = 1'b1;

    // Enter EDIT_MIN
    exp_q.push_back(mk(1'b0, 3, 0, 1));
    press(B_MODE, 3);

    // 2-cycle glitch must not step
    @(negedge clk); btn_up = 1'b1;
    repeat (2) @(negedge clk); btn_up = 1'b0;
    repeat (10) @(negedge clk);
    check_now(mk(1'b0, 3, 0, 1), "glitch_no_step");

    // Edit flow: up x2, mode, down, confirm
    exp_q.push_back(mk(1'b0, 4, 0, 1));  press(B_UP, 3);
    exp_q.push_back(mk(1'b0, 5, 0, 1));  press(B_UP, 3);
    exp_q.push_back(mk(1'b0, 5, 0, 2));  press(B_MODE, 3);
    exp_q.push_back(mk(1'b0, 5, 59, 2)); press(B_DOWN, 3);
    exp_q.push_back(mk(1'b1, 5, 59, 0)); press(B_CONF, 3);

    // OFFER with set_ready low: presses ignored, values held
    press(B_UP, 3);
    press(B_MODE, 3);
    press(B_CONF, 3);
    check_now(mk(1'b1, 5, 59, 0), "offer_hold");

    exp_q.push_back(mk(1'b0, 5, 59, 0));
    set_ready = 1'b1;
    @(negedge clk);
    check_now(mk(1'b0, 5, 59, 0), "handshake_idle");

    // set_ready in IDLE has no effect; up/confirm ignored in IDLE
    press(B_UP, 3);
    press(B_CONF, 3);
    set_ready = 1'b0;

    // Minutes wrap 0->99->0
    exp_q.push_back(mk(1'b0, 5, 59, 1)); press(B_MODE, 3);
    for (int m = 4; m >= 0; m--) begin
      exp_q.push_back(mk(1'b0, m, 59, 1));
      press(B_DOWN, 3);
    end
    exp_q.push_back(mk(1'b0, 99, 59, 1)); press(B_DOWN, 3);
    exp_q.push_back(mk(1'b0, 0, 59, 1));  press(B_UP, 3);

    // Coincident up+down cancel
    press(B_UP | B_DOWN, 3);

    // Mode beats up; seconds wrap 59->0->59
    exp_q.push_back(mk(1'b0, 0, 59, 2)); press(B_MODE | B_UP, 3);
    exp_q.push_back(mk(1'b0, 0, 0, 2));  press(B_UP, 3);
    exp_q.push_back(mk(1'b0, 0, 59, 2)); press(B_DOWN, 3);
    exp_q.push_back(mk(1'b0, 0, 59, 1)); press(B_MODE, 3);

    // Confirm beats mode in EDIT_MIN
    exp_q.push_back(mk(1'b1, 0, 59, 0)); press(B_MODE | B_CONF, 3);

    // Reset in the middle of OFFER
    exp_q.push_back(mk(1'b0, 3, 0, 0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_now(mk(1'b0, 3, 0, 0), "reset_mid_offer");

    // After reset, a mode press must again enter EDIT_MIN
    exp_q.push_back(mk(1'b0, 3, 0, 1)); press(B_MODE, 3);

    waited = 0;
    while (exp_q.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
